maze_game_ctrl: RTL
===================

Name: maze_game_ctrl

Overview:
Game-sequencing controller for the 8x8 dot-matrix maze. It takes the debounced start and four direction pulses, arbitrates between them, and checks each move against board bounds and a per-level wall map. It owns the player position, step count and game state (idle/play/win/lose). Its outputs feed the matrix scan/display logic.

Parameters:
WALL_MAP_0, 64'h0, level-0 wall bitmap; bit index = row*8+col; 1 = wall
WALL_MAP_1, 64'h0, level-1 wall bitmap, same indexing
MAX_STEPS, 63, step budget per game; reaching it without winning gives LOSE
STEP_W, 7, width of step counter; MAX_STEPS must be < 2**STEP_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse (debounced); begin/restart a game
level_sel  in  1  level choice, sampled only on start
dir_row_inc  in  1  one-cycle pulse: move row+1
dir_row_dec  in  1  one-cycle pulse: move row-1
dir_col_dec  in  1  one-cycle pulse: move col-1
dir_col_inc  in  1  one-cycle pulse: move col+1
loc_row  out  3  player row
loc_col  out  3  player column
term_row  out  3  terminal row of active level
term_col  out  3  terminal column of active level
step_cnt  out  STEP_W  accepted moves this game
game_state  out  2  0 IDLE, 1 PLAY, 2 WIN, 3 LOSE
move_ok  out  1  one-cycle pulse: move accepted
move_blocked  out  1  one-cycle pulse: move rejected (bound or wall)

Behaviour:
- Single clock domain. All outputs are registered. Reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values: game_state=IDLE, level=0, loc=(6,7), term=(0,0), step_cnt=0, move_ok=0, move_blocked=0.
- Level table (fixed):
  - Level 0: start (6,7), terminal (0,0).
  - Level 1: start (7,6), terminal (1,7).
- Start handling: start=1 in any state at an edge does the following:
  - Latch level_sel.
  - Load that level's start and terminal points; step_cnt=0.
  - game_state=PLAY, no pulses.
  - Start outranks any direction pulse in the same cycle; that direction pulse is dropped.
- IDLE, WIN, LOSE: direction pulses are ignored. No pulses are emitted, and position and step_cnt are held.
- PLAY arbitration: fixed priority row_inc > row_dec > col_dec > col_inc. Only the winning request is evaluated; losing requests in the same cycle are discarded, not queued.
- Move legality: the target cell must be in the range 0..7 (row_inc needs row<7, row_dec row>0, col_dec col>0, col_inc col<7), and the wall bit of the active level's map at the target must be 0.
- Legal move: at the next edge, loc updates, step_cnt+1 and move_ok=1.
- Illegal move: loc and step_cnt unchanged, move_blocked=1.
- Latency: one cycle from direction pulse to updated loc and pulse.
- End of game, evaluated at the same edge as the accepted move:
  - New position equals terminal → WIN.
  - Otherwise, step_cnt+1 == MAX_STEPS → LOSE.
  - WIN takes precedence when both hold.
- Blocked moves never consume steps.
- step_cnt never wraps; it is frozen once the game leaves PLAY.
- Reset mid-game: returns to the reset values on the next edge regardless of pending pulses; reset outranks start.
- A held (multi-cycle) direction level yields one move per cycle. Upstream delivers pulses only.

Decomposition:
- Package maze_pkg contains:
  - game_state enum (IDLE/PLAY/WIN/LOSE);
  - 3-bit coordinate type;
  - level start/terminal constants;
  - direction-index encoding.
- Sub-module maze_move_check: purely combinational. Inputs are the four requests, current loc and active wall map. Outputs are winner valid, legal flag and target loc. The controller instantiates it once.

Test Plan:
- Reset then start with level_sel=0 → next cycle game_state=1, loc=(6,7), step_cnt=0, term=(0,0).
- PLAY at (6,7) with empty map: dir_row_inc → loc=(7,7), move_ok=1, step=1. Then dir_row_inc again → move_blocked=1, loc stays (7,7), step stays 1.
- WALL_MAP_0 bit 54 set (cell 6,6), at (6,7): dir_col_dec → move_blocked=1. Same cycle dir_row_dec+dir_col_inc → only row_dec is evaluated; loc=(5,7).
- Level 0, empty map: drive 6 row_dec then 7 col_dec → after the 13th move loc=(0,0), game_state=WIN, step=13. Further directions are ignored.
- MAX_STEPS=4, level 1, moves that avoid the terminal → state LOSE on the 4th accepted move with step=4. MAX_STEPS=1 with a start adjacent to the terminal via a custom constant → WIN, not LOSE.
- Mid-game (step=5):
  - start with level_sel=1 plus a simultaneous dir pulse → loc=(7,6), step=0, PLAY, no move pulse.
  - rst asserted together with start → all reset values.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the 8x8 maze game controller.
package maze_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } game_state_t;

    typedef logic [2:0] coord_t;

    typedef struct packed {
        coord_t row;
        coord_t col;
    } loc_t;

    typedef enum logic [1:0] {
        DIR_ROW_INC = 2'd0,
        DIR_ROW_DEC = 2'd1,
        DIR_COL_DEC = 2'd2,
        DIR_COL_INC = 2'd3
    } dir_t;

    localparam coord_t COORD_MIN = 3'd0;
    localparam coord_t COORD_MAX = 3'd7;

    localparam loc_t RESET_LOC = '{row: 3'd6, col: 3'd7};
    localparam loc_t RESET_TERM = '{row: 3'd0, col: 3'd0};

    localparam loc_t L0_START = '{row: 3'd6, col: 3'd7};
    localparam loc_t L0_TERM = '{row: 3'd0, col: 3'd0};
    localparam loc_t L1_START = '{row: 3'd7, col: 3'd6};
    localparam loc_t L1_TERM = '{row: 3'd1, col: 3'd7};

    // Wall bitmap index: row*8 + col.
    function automatic logic [5:0] cell_idx(input loc_t l);
        return {l.row, l.col};
    endfunction

endpackage

// File: rtl/maze_move_check.sv
// Picks the winning direction request and judges it against bounds
// and the active wall map. Purely combinational.
module maze_move_check
    import maze_pkg::*;
(
    input  logic        row_inc,
    input  logic        row_dec,
    input  logic        col_dec,
    input  logic        col_inc,
    input  loc_t        loc,
    input  logic [63:0] wall_map,
    output logic        valid,
    output logic        legal,
    output loc_t        target
);

    dir_t dir;
    logic in_bounds;

    assign valid = row_inc | row_dec | col_dec | col_inc;

    // Fixed priority; losers are simply dropped.
    always_comb begin
        dir = DIR_COL_INC;
        if (row_inc) begin
            dir = DIR_ROW_INC;
        end else if (row_dec) begin
            dir = DIR_ROW_DEC;
        end else if (col_dec) begin
            dir = DIR_COL_DEC;
        end
    end

    always_comb begin
        target    = loc;
        in_bounds = 1'b0;
        unique case (dir)
            DIR_ROW_INC: begin
                in_bounds  = (loc.row != COORD_MAX);
                target.row = loc.row + 3'd1;
            end
            DIR_ROW_DEC: begin
                in_bounds  = (loc.row != COORD_MIN);
                target.row = loc.row - 3'd1;
            end
            DIR_COL_DEC: begin
                in_bounds  = (loc.col != COORD_MIN);
                target.col = loc.col - 3'd1;
            end
            DIR_COL_INC: begin
                in_bounds  = (loc.col != COORD_MAX);
                target.col = loc.col + 3'd1;
            end
            default: begin
                in_bounds = 1'b0;
            end
        endcase
    end

    assign legal = valid && in_bounds && !wall_map[cell_idx(target)];

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: start/restart, move arbitration and legality,
// player position, step budget and win/lose tracking.
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter logic [63:0] WALL_MAP_0 = 64'h0,
    parameter logic [63:0] WALL_MAP_1 = 64'h0,
    parameter int          MAX_STEPS  = 63,
    parameter int          STEP_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              level_sel,
    input  logic              dir_row_inc,
    input  logic              dir_row_dec,
    input  logic              dir_col_dec,
    input  logic              dir_col_inc,
    output logic [2:0]        loc_row,
    output logic [2:0]        loc_col,
    output logic [2:0]        term_row,
    output logic [2:0]        term_col,
    output logic [STEP_W-1:0] step_cnt,
    output logic [1:0]        game_state,
    output logic              move_ok,
    output logic              move_blocked
);

    localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

    game_state_t       state_q, state_d;
    logic              level_q, level_d;
    loc_t              loc_q, loc_d;
    loc_t              term_q, term_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              ok_q, ok_d;
    logic              blk_q, blk_d;

    logic              req_valid;
    logic              req_legal;
    loc_t              target;
    logic [63:0]       wall_map;
    logic [STEP_W-1:0] step_inc;
    logic              do_move;

    assign wall_map = level_q ? WALL_MAP_1 : WALL_MAP_0;
    assign step_inc = step_q + STEP_ONE;
    assign do_move  = (state_q == PLAY) && req_valid && !start;

    maze_move_check u_move_check (
        .row_inc  (dir_row_inc),
        .row_dec  (dir_row_dec),
        .col_dec  (dir_col_dec),
        .col_inc  (dir_col_inc),
        .loc      (loc_q),
        .wall_map (wall_map),
        .valid    (req_valid),
        .legal    (req_legal),
        .target   (target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= 1'b0;
            loc_q   <= RESET_LOC;
            term_q  <= RESET_TERM;
            step_q  <= '0;
            ok_q    <= 1'b0;
            blk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            loc_q   <= loc_d;
            term_q  <= term_d;
            step_q  <= step_d;
            ok_q    <= ok_d;
            blk_q   <= blk_d;
        end
    end

    // WIN is checked before the step budget so a last-step arrival wins.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = PLAY;
        end else if (do_move && req_legal) begin
            if (target == term_q) begin
                state_d = WIN;
            end else if (step_inc == STEP_LIMIT) begin
                state_d = LOSE;
            end
        end
    end

    always_comb begin
        level_d = level_q;
        loc_d   = loc_q;
        term_d  = term_q;
        step_d  = step_q;
        ok_d    = 1'b0;
        blk_d   = 1'b0;
        if (start) begin
            level_d = level_sel;
            loc_d   = level_sel ? L1_START : L0_START;
            term_d  = level_sel ? L1_TERM : L0_TERM;
            step_d  = '0;
        end else if (do_move) begin
            if (req_legal) begin
                loc_d  = target;
                step_d = step_inc;
                ok_d   = 1'b1;
            end else begin
                blk_d  = 1'b1;
            end
        end
    end

    assign loc_row      = loc_q.row;
    assign loc_col      = loc_q.col;
    assign term_row     = term_q.row;
    assign term_col     = term_q.col;
    assign step_cnt     = step_q;
    assign game_state   = state_q;
    assign move_ok      = ok_q;
    assign move_blocked = blk_q;

endmodule
